// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, single-entry output
// register to decode, redirect flush with stale-response kill.
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            taken,
  input  logic [XLEN-1:0] BranchTarget,
  input  logic            Jump,
  input  logic [XLEN-1:0] JumpTarget,
  input  logic            Stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            IF_valid,
  output logic [XLEN-1:0] IF_pc,
  output logic [XLEN-1:0] IF_instr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            kill_r;
  logic            if_valid_r;
  logic [XLEN-1:0] if_pc_r;
  logic [XLEN-1:0] if_instr_r;

  logic            redirect_s;
  logic [XLEN-1:0] sel_target_s;
  logic [XLEN-1:0] target_s;
  logic            issue_ok_s;
  logic            req_s;
  logic            load_s;

  // Redirect decode, issue gating and response acceptance
  always_comb begin
    redirect_s   = taken | Jump;
    sel_target_s = BranchTarget;
    if (Jump) begin
      sel_target_s = JumpTarget;
    end else begin
      sel_target_s = BranchTarget;
    end
    target_s   = sel_target_s & WORD_MASK;
    issue_ok_s = ~if_valid_r | ~Stall;
    req_s      = (state_r == REQ) & issue_ok_s & ~redirect_s;
    // A redirect in the response cycle drops the data without touching kill
    load_s     = (state_r == WAIT) & imem_rvalid & ~kill_r & ~redirect_s;
  end

  // Fetch sequencer: PC, outstanding-request tracking and kill flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
      kill_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= REQ;
          if (redirect_s) begin
            pc_r <= target_s;
          end
        end
        REQ: begin
          if (redirect_s) begin
            pc_r <= target_s;
          end else if (req_s && imem_ready) begin
            req_pc_r <= pc_r;
            pc_r     <= pc_r + PC_STEP;
            state_r  <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_s) begin
            pc_r <= target_s;
            if (imem_rvalid) begin
              kill_r  <= 1'b0;
              state_r <= REQ;
            end else begin
              kill_r <= 1'b1;
            end
          end else if (imem_rvalid) begin
            kill_r  <= 1'b0;
            state_r <= REQ;
          end
        end
        default: begin
          state_r <= IDLE;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

  // Decode-facing output register: load, flush, drain or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_r <= 1'b0;
      if_pc_r    <= '0;
      if_instr_r <= NOP_INSTR;
    end else begin
      if (load_s) begin
        if_valid_r <= 1'b1;
        if_pc_r    <= req_pc_r;
        if_instr_r <= imem_rdata;
      end else if (redirect_s) begin
        if_valid_r <= 1'b0;
      end else if (if_valid_r && !Stall) begin
        if_valid_r <= 1'b0;
      end
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_r;
  assign IF_valid  = if_valid_r;
  assign IF_pc     = if_pc_r;
  assign IF_instr  = if_instr_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level reference model
// (queue of in-flight fetches, each possibly marked stale by a redirect).
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        taken, Jump, Stall;
  logic [31:0] BranchTarget, JumpTarget;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        IF_valid;
  logic [31:0] IF_pc, IF_instr;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .taken(taken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .Stall(Stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_valid(IF_valid), .IF_pc(IF_pc), .IF_instr(IF_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } fetch_t;

  // Reference model state
  fetch_t      inflight[$];
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_ov;
  logic [31:0] m_opc, m_oinstr;

  // Memory responder state
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_pc      = RESET_PC;
    inflight.delete();
    m_ov      = 1'b0;
    m_opc     = 32'h0000_0000;
    m_oinstr  = 32'h0000_0013;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0203;
      2:       return 32'h0000_0100;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit          do_rst, redirect, exp_req, accept;
    logic [31:0] tgt;
    fetch_t      f;

    taken = 1'b0; Jump = 1'b0; Stall = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; BranchTarget = 32'h0; JumpTarget = 32'h0; imem_rdata = 32'h0;
    model_reset();
    mem_pend = 1'b0; mem_cnt = 0; mem_data = 32'h0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      do_rst = (cyc < 2) || (inflight.size() != 0 && $urandom_range(0, 149) == 0);
      rst_n  = !do_rst;
      if (do_rst) begin
        model_reset();
        if (mem_pend) mem_cnt = 0;  // pre-reset response returns while DUT is held/idle
      end

      taken        = ($urandom_range(0, 9) == 0);
      Jump         = ($urandom_range(0, 15) == 0);
      BranchTarget = pick_target();
      JumpTarget   = pick_target();
      Stall        = ($urandom_range(0, 2) == 0);
      imem_ready   = ($urandom_range(0, 3) != 0);
      if (mem_pend) begin
        imem_rvalid = (mem_cnt == 0);
        imem_rdata  = mem_data;
      end else begin
        imem_rvalid = ($urandom_range(0, 7) == 0);
        imem_rdata  = $urandom;
      end

      redirect = taken | Jump;
      tgt      = (Jump ? JumpTarget : BranchTarget) & 32'hFFFF_FFFC;
      exp_req  = m_started && inflight.size() == 0 && (!m_ov || !Stall) && !redirect;

      #1;
      check_val("imem_req",  {31'b0, imem_req}, {31'b0, exp_req});
      check_val("imem_addr", imem_addr, m_pc);
      check_val("IF_valid",  {31'b0, IF_valid}, {31'b0, m_ov});
      check_val("IF_pc",     IF_pc, m_opc);
      check_val("IF_instr",  IF_instr, m_oinstr);

      if (!do_rst) begin
        accept = (inflight.size() != 0) && imem_rvalid;
        if (accept && !inflight[0].stale && !redirect) begin
          m_ov     = 1'b1;
          m_opc    = inflight[0].addr;
          m_oinstr = imem_rdata;
        end else if (redirect) begin
          m_ov = 1'b0;
        end else if (m_ov && !Stall) begin
          m_ov = 1'b0;
        end
        if (accept) begin
          void'(inflight.pop_front());
        end else if (redirect && inflight.size() != 0) begin
          f = inflight[0];
          f.stale = 1'b1;
          inflight[0] = f;
        end
        if (redirect) begin
          m_pc = tgt;
        end else if (exp_req && imem_ready) begin
          f.addr  = m_pc;
          f.stale = 1'b0;
          inflight.push_back(f);
          m_pc = m_pc + 32'd4;
        end
        m_started = 1'b1;
      end

      if (mem_pend && imem_rvalid) begin
        mem_pend = 1'b0;
      end else if (mem_pend) begin
        mem_cnt--;
      end
      if (!do_rst && exp_req && imem_ready) begin
        mem_pend = 1'b1;
        mem_cnt  = $urandom_range(0, 2);
        mem_data = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that directly consumes the branch unit's taken decision.
- Holds the PC and issues one instruction-memory request at a time over a valid/ready request and response interface.
- Presents fetched instructions to decode through a single-entry output register.
- On a redirect (branch taken or jump), loads the new target, flushes the output register and discards any in-flight stale response.

Parameters:
XLEN, 32, width of PC, addresses and instruction word
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
taken  input  1  branch taken from branch unit
BranchTarget  input  XLEN  branch target address
Jump  input  1  unconditional jump (jal/jalr) resolved in EX
JumpTarget  input  XLEN  jump target address
Stall  input  1  decode cannot accept; hold output register
imem_req  output  1  request valid
imem_addr  output  XLEN  request address
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid
imem_rdata  input  XLEN  response instruction
IF_valid  output  1  output register holds a valid instruction
IF_pc  output  XLEN  PC of IF_instr
IF_instr  output  XLEN  fetched instruction

Behaviour:
- Reset is asynchronous and active-low on rst_n, with clock clk.
- Reset values: pc=RESET_PC, state=IDLE, kill=0, imem_req=0, imem_addr=RESET_PC, IF_valid=0, IF_pc=0, IF_instr=32'h0000_0013 (nop).
- Redirect:
  - redirect = taken | Jump.
  - target = Jump ? JumpTarget : BranchTarget (Jump has priority if both are set).
  - target[1:0] is forced to 2'b00.
- Issue condition: issue_ok = ~IF_valid | ~Stall.
- States:
  - IDLE: entered after reset. Moves to REQ on the next edge. imem_req=0.
  - REQ:
    - imem_req = issue_ok & ~redirect; imem_addr = pc.
    - A handshake is imem_req & imem_ready. On handshake: latch req_pc=pc, pc<=pc+4, go to WAIT.
    - If redirect: no request this cycle, pc<=target, stay in REQ.
  - WAIT: imem_req=0. On imem_rvalid:
    - If kill=0: load IF_instr=imem_rdata, IF_pc=req_pc, IF_valid=1.
    - If kill=1: drop the response and clear kill.
    - In both cases, return to REQ.
- Redirect in WAIT:
  - Sets kill=1 and pc<=target.
  - If imem_rvalid arrives in the same cycle, the response is dropped directly and the block goes to REQ with kill=0.
- Flush: any redirect clears IF_valid on the next edge, regardless of Stall. A response accepted in the same cycle is not written.
- Output register:
  - Holds its value while IF_valid & Stall.
  - Cleared (IF_valid=0) when consumed (IF_valid & ~Stall) unless reloaded that same edge.
- Outstanding requests: at most one. A response always lands in a free output register, because issue only happens when the register is empty or draining.
- Throughput: one instruction per 2 cycles minimum (accept, then response). Responses are accepted no earlier than the cycle after the handshake.
- PC arithmetic: pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- Reset mid-operation: all state is cleared immediately. A response to a pre-reset request is ignored, because the block is in IDLE or REQ with no request outstanding.
- imem_rvalid outside WAIT: ignored.

Test Plan:
- Reset then free-run with zero-wait memory (ready=1, rvalid one cycle after accept) -> imem_addr sequence 0,4,8,C; IF_pc follows with IF_valid pulses every 2 cycles; IF_instr matches rdata.
- Stall=1 with IF_valid=1 for 5 cycles -> IF_pc/IF_instr unchanged, imem_req=0 throughout; Stall drops -> next request issues the same cycle.
- taken=1, BranchTarget=0x100 while in WAIT for addr 0x8, rvalid two cycles later with rdata=0xDEADBEEF -> that response is discarded, IF_valid stays 0, next imem_addr=0x100.
- Jump=1, JumpTarget=0x203 together with taken=1, BranchTarget=0x40 -> next fetch address 0x200; IF_valid cleared even with Stall=1.
- Redirect in the same cycle imem_rvalid returns -> response dropped, kill remains 0, the following response at target is accepted.
- pc=0xFFFF_FFFC accepted -> next imem_addr=0x0; assert rst_n=0 while in WAIT, then return an rvalid -> IF_valid stays 0, fetch restarts at RESET_PC.
